// File: rtl/controlador_entradas_pkg.sv
// Shared constants for the 16-input debounced operand front end.
// Holds the default debounce length, the operand width and the input count.
package controlador_entradas_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int OPERAND_W           = 8;
    localparam int N_INPUTS            = 16;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/controlador_entradas_antirrebote.sv
// One-bit debouncer: two-flop synchronizer, run-length counter and output flop.
// toggle_o is high in the cycle before the output flop flips.
module antirrebote
    import controlador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic toggle_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          toggle;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        out_d   = out_q;
        cnt_d   = '0;
        toggle  = 1'b0;
        // Counter only ever reaches DEBOUNCE_CYCLES-1, so it cannot wrap.
        if (sync2_q != out_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                toggle = 1'b1;
                out_d  = ~out_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout     = out_q;
    assign toggle_o = toggle;

endmodule

// File: rtl/controlador_entradas.sv
// Debounces sixteen raw switch levels into two 8-bit operands A and B,
// with a single-cycle cambio pulse whenever either operand updates.
module controlador_entradas
    import controlador_entradas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic       i8,
    input  logic       i9,
    input  logic       i10,
    input  logic       i11,
    input  logic       i12,
    input  logic       i13,
    input  logic       i14,
    input  logic       i15,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       cambio
);

    logic [N_INPUTS-1:0] raw;
    logic [N_INPUTS-1:0] deb;
    logic [N_INPUTS-1:0] toggle;
    logic                cambio_q, cambio_d;

    assign raw = {i15, i14, i13, i12, i11, i10, i9, i8,
                  i7,  i6,  i5,  i4,  i3,  i2,  i1, i0};

    for (genvar k = 0; k < N_INPUTS; k++) begin : g_bit
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (raw[k]),
            .dout    (deb[k]),
            .toggle_o(toggle[k])
        );
    end

    // Registered so the pulse lines up with the cycle the new operand appears.
    always_comb begin
        cambio_d = |toggle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cambio_q <= 1'b0;
        end else begin
            cambio_q <= cambio_d;
        end
    end

    assign A      = deb[OPERAND_W-1:0];
    assign B      = deb[2*OPERAND_W-1:OPERAND_W];
    assign cambio = cambio_q;

endmodule

// File: tb/tb_controlador_entradas.sv
// Scenario bench for controlador_entradas at the default debounce length of 4.
// Expected operand/cambio values are queued per cycle and popped as the DUT advances.
module tb_controlador_entradas;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_v;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        cambio;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    controlador_entradas dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (in_v[0]),
        .i1    (in_v[1]),
        .i2    (in_v[2]),
        .i3    (in_v[3]),
        .i4    (in_v[4]),
        .i5    (in_v[5]),
        .i6    (in_v[6]),
        .i7    (in_v[7]),
        .i8    (in_v[8]),
        .i9    (in_v[9]),
        .i10   (in_v[10]),
        .i11   (in_v[11]),
        .i12   (in_v[12]),
        .i13   (in_v[13]),
        .i14   (in_v[14]),
        .i15   (in_v[15]),
        .A     (A),
        .B     (B),
        .cambio(cambio)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_n(input int n, input logic [7:0] a, input logic [7:0] b, input logic c);
        for (int i = 0; i < n; i++) sb_q.push_back('{a: a, b: b, c: c});
    endtask

    task automatic reset_to(input logic [15:0] v);
        @(negedge clk);
        in_v = v;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_v  = 16'hFFFF;
        #1;
        checks++;
        if ({A, B, cambio} !== 17'h0) begin
            errors++;
            $display("FAIL reset_initial got A=%h B=%h cambio=%b want 00 00 0", A, B, cambio);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_n(5, 8'h00, 8'h00, 1'b0);
        push_n(1, 8'hFF, 8'hFF, 1'b1);
        push_n(1, 8'hFF, 8'hFF, 1'b0);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                errors++;
                $display("FAIL release_all_high edge %0d got A=%h B=%h c=%b want A=%h B=%h c=%b",
                         cyc, A, B, cambio, e.a, e.b, e.c);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, cambio} !== 17'h0) begin
            errors++;
            $display("FAIL reset_async got A=%h B=%h cambio=%b want 00 00 0", A, B, cambio);
        end
    endtask

    task automatic test_mapping();
        in_v = 16'hF0AA;
        @(negedge clk);
        rst_n = 1'b1;
        push_n(5, 8'h00, 8'h00, 1'b0);
        push_n(1, 8'hAA, 8'hF0, 1'b1);
        push_n(2, 8'hAA, 8'hF0, 1'b0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                errors++;
                $display("FAIL mapping edge %0d got A=%h B=%h c=%b want A=%h B=%h c=%b",
                         cyc, A, B, cambio, e.a, e.b, e.c);
            end
        end
    endtask

    task automatic test_glitch();
        reset_to(16'h0000);
        for (int pw = 2; pw <= 4; pw++) begin
            if (pw < 4) begin
                push_n(12, 8'h00, 8'h00, 1'b0);
            end else begin
                push_n(5, 8'h00, 8'h00, 1'b0);
                push_n(1, 8'h08, 8'h00, 1'b1);
                push_n(3, 8'h08, 8'h00, 1'b0);
                push_n(1, 8'h00, 8'h00, 1'b1);
                push_n(2, 8'h00, 8'h00, 1'b0);
            end
            for (int cyc = 0; cyc < 12; cyc++) begin
                in_v[3] = (cyc < pw);
                @(posedge clk);
                @(negedge clk);
                e = sb_q.pop_front();
                checks++;
                if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                    errors++;
                    $display("FAIL glitch_w%0d edge %0d got A=%h B=%h c=%b want A=%h B=%h c=%b",
                             pw, cyc + 1, A, B, cambio, e.a, e.b, e.c);
                end
            end
        end
    endtask

    task automatic test_latency();
        reset_to(16'h0000);
        for (int dir = 1; dir >= 0; dir--) begin
            in_v[15] = dir[0];
            push_n(5, 8'h00, dir[0] ? 8'h00 : 8'h80, 1'b0);
            push_n(1, 8'h00, dir[0] ? 8'h80 : 8'h00, 1'b1);
            push_n(1, 8'h00, dir[0] ? 8'h80 : 8'h00, 1'b0);
            for (int cyc = 1; cyc <= 7; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                e = sb_q.pop_front();
                checks++;
                if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                    errors++;
                    $display("FAIL latency_i15_to_%0d edge %0d got B=%h c=%b want B=%h c=%b",
                             dir, cyc, B, cambio, e.b, e.c);
                end
            end
        end
    endtask

    task automatic test_independence();
        reset_to(16'h0000);
        push_n(5, 8'h00, 8'h00, 1'b0);
        push_n(1, 8'h01, 8'h00, 1'b1);
        push_n(2, 8'h01, 8'h00, 1'b0);
        push_n(1, 8'h01, 8'h01, 1'b1);
        push_n(2, 8'h01, 8'h01, 1'b0);
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc == 0) in_v[0] = 1'b1;
            if (cyc == 3) in_v[8] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                errors++;
                $display("FAIL independence edge %0d got A=%h B=%h c=%b want A=%h B=%h c=%b",
                         cyc + 1, A, B, cambio, e.a, e.b, e.c);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_to(16'h0000);
        in_v[5] = 1'b1;
        push_n(3, 8'h00, 8'h00, 1'b0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                errors++;
                $display("FAIL mid_pre edge %0d got A=%h c=%b want A=%h c=%b",
                         cyc, A, cambio, e.a, e.c);
            end
        end
        #2 rst_n = 1'b0;
        in_v[5] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_n(10, 8'h00, 8'h00, 1'b0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({A, B, cambio} !== {e.a, e.b, e.c}) begin
                errors++;
                $display("FAIL mid_post edge %0d got A=%h B=%h c=%b want A=%h B=%h c=%b",
                         cyc, A, B, cambio, e.a, e.b, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_glitch();
        test_latency();
        test_independence();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_entradas.md
CONTROLADOR_ENTRADAS -- requirements
Module: controlador_entradas

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles an input must hold a new level before it is accepted; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i0..i15  input  1 each  raw, asynchronous switch/pushbutton levels.
REQ-005 SHALL have port A  output  8  debounced operand A; A[k] follows ik, k=0..7, i0 = LSB.
REQ-006 SHALL have port B  output  8  debounced operand B; B[k] follows i(k+8), k=0..7, i8 = LSB.
REQ-007 SHALL have port cambio  output  1  one-cycle pulse marking an update of A or B.

Function
REQ-008 SHALL pass each of the 16 inputs through a two-flip-flop synchronizer before any other use.
REQ-009 SHALL keep, per bit, a counter of consecutive cycles in which the synchronized level differs from the current output bit.
REQ-010 SHALL clear a bit's counter on any cycle in which the synchronized level equals the output bit.
REQ-011 SHALL toggle an output bit on the edge at which its counter would reach DEBOUNCE_CYCLES, and SHALL clear that counter on the same edge.
REQ-012 SHALL make a clean input transition held steady visible on its output bit exactly DEBOUNCE_CYCLES+2 rising edges after it is sampled (6 edges at the default).
REQ-013 SHALL ignore any pulse or glitch whose synchronized duration is shorter than DEBOUNCE_CYCLES cycles; the output bit SHALL not change.
REQ-014 SHALL treat all 16 bits independently; simultaneous changes on several inputs SHALL update each bit on its own schedule, with no cross-bit interaction.
REQ-015 SHALL drive A and B directly from registers, with no combinational path from i0..i15.
REQ-016 SHALL assert cambio for exactly one cycle, coinciding with the first cycle the new A/B value is visible, whenever one or more bits of A or B change on that edge; several bits changing on the same edge SHALL produce a single pulse.
REQ-017 SHALL size counters as clog2(DEBOUNCE_CYCLES+1) bits; counters SHALL never wrap.

Reset
REQ-018 SHALL, while rst_n = 0, immediately force A = 8'h00, B = 8'h00, cambio = 0, all synchronizer flops to 0 and all counters to 0, independent of clk.
REQ-019 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; inputs already high SHALL appear after DEBOUNCE_CYCLES+2 edges, and cambio SHALL pulse at that point.
REQ-020 SHALL, if reset asserts mid-debounce, discard the partial count; no output change SHALL result from pre-reset activity.

Structure
REQ-021 SHALL place DEBOUNCE_CYCLES default, the operand width (8) and the input count (16) in a shared package, controlador_entradas_pkg.
REQ-022 SHALL implement a one-bit sub-module, antirrebote (synchronizer + counter + output flop), instantiated 16 times; the top SHALL only map bits and generate cambio.

Verification
REQ-023 SHALL verify reset: rst_n = 0 with all inputs at 1 -> A = 00, B = 00, cambio = 0 asynchronously, without a clock edge.
REQ-024 SHALL verify the mapping: i0..i15 = 0,1,0,1,0,1,0,1,0,0,0,0,1,1,1,1 after reset release -> A = 8'hAA, B = 8'hF0 after 6 edges, and a single cambio pulse.
REQ-025 SHALL verify glitch rejection: i3 pulsed high for 2 cycles (DEBOUNCE_CYCLES = 4) -> A unchanged, no cambio.
REQ-026 SHALL verify latency: i15 0->1 held -> B[7] rises exactly on the 6th edge, not the 5th; cambio high for that single cycle.
REQ-027 SHALL verify independence: i0 and i8 toggled 3 cycles apart -> A[0] and B[0] each update 6 edges after their own change, with two separate cambio pulses.
REQ-028 SHALL verify reset mid-debounce: i5 changes, rst_n asserted 3 cycles later, then released with i5 back low -> A stays 00.
